// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: one round key per cycle into an 11-slot store.
// The read port is either registered or combinational, chosen by REG_RD.
module aes_key_schedule #(
    parameter int unsigned REG_RD = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    localparam int unsigned KEY_W      = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned NUM_SLOTS  = 11;
    localparam int unsigned LAST_ROUND = 10;

    // FIPS-197 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE,
        EXPAND
    } state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k,
                                                  input logic [7:0]       rc);
        logic [WORD_W-1:0] rot;
        logic [WORD_W-1:0] t;
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h000000};
        w0  = k[127:96] ^ t;
        w1  = k[95:64]  ^ w0;
        w2  = k[63:32]  ^ w1;
        w3  = k[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    endfunction

    state_e           state_q, state_d;
    logic [IDX_W-1:0] round_q, round_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [KEY_W-1:0] slot_q [NUM_SLOTS];
    logic [KEY_W-1:0] slot_d [NUM_SLOTS];
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [KEY_W-1:0] prev_key_c;
    logic [KEY_W-1:0] next_key_c;
    logic [KEY_W-1:0] rd_sel_c;

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = valid_q;

    // Next-state: capture key in IDLE, derive slot[round] from slot[round-1] in EXPAND
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        slot_d     = slot_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        prev_key_c = '0;
        for (int i = 0; i < int'(LAST_ROUND); i++) begin
            if (round_q == IDX_W'(i + 1)) begin
                prev_key_c = slot_q[i];
            end
        end
        next_key_c = next_key(prev_key_c, rcon_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    slot_d[0] = key_in;
                    rcon_d    = 8'h01;
                    round_d   = IDX_W'(1);
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i < int'(NUM_SLOTS); i++) begin
                    if (round_q == IDX_W'(i)) begin
                        slot_d[i] = next_key_c;
                    end
                end
                round_d = round_q + IDX_W'(1);
                rcon_d  = xtime(rcon_q);
                if (round_q == IDX_W'(LAST_ROUND)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Out-of-range indices fall through to zero
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel_c = slot_q[i];
            end
        end
    end

    if (REG_RD != 0) begin : g_reg_rd
        logic [KEY_W-1:0] rd_key_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_key_q <= '0;
            end else begin
                rd_key_q <= rd_sel_c;
            end
        end
        assign rd_key = rd_key_q;
    end else begin : g_comb_rd
        assign rd_key = rd_sel_c;
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule (REG_RD=1): FIPS-197 vectors, latency,
// ignored/back-to-back starts, mid-expansion reset; reads checked via a scoreboard queue.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks = 0;
    int passes = 0;

    logic [127:0] exp_q [$];
    string        tag_q [$];

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    logic [127:0] a1_rk [11];
    logic [127:0] z_rk1, z_rk2, z_rk10;

    aes_key_schedule #(.REG_RD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive start for one edge; key_in is scrambled afterwards to expose re-sampling
    task automatic start_exp(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        check1("busy_after_start", busy, 1'b1);
        check1("valid_low_after_start", keys_valid, 1'b0);
    endtask

    // Count cycles after the start edge until done, bounded
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
    endtask

    // Scoreboard read: expectation queued when rd_idx is driven, compared after the edge
    task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        rd_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        check128(tag_q.pop_front(), rd_key, exp_q.pop_front());
    endtask

    task automatic check_done_phase(input string tag, input int n);
        check_int({tag, "_latency"}, n, 10);
        check1({tag, "_busy_at_done"}, busy, 1'b0);
        check1({tag, "_valid_at_done"}, keys_valid, 1'b1);
    endtask

    initial begin
        int n;
        a1_rk[0]  = KEY_A1;
        a1_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        z_rk1     = 128'h62636363626363636263636362636363;
        z_rk2     = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
        z_rk10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        rd_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_valid", keys_valid, 1'b0);
        check128("rst_rd_key", rd_key, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 A.1 expansion
        start_exp(KEY_A1);
        wait_done(0, n);
        check_done_phase("a1", n);
        @(posedge clk); #1;
        check1("a1_done_one_cycle", done, 1'b0);
        check1("a1_valid_holds", keys_valid, 1'b1);
        for (int i = 0; i < 11; i++) begin
            rd(4'(i), a1_rk[i], $sformatf("a1_slot%0d", i));
        end
        rd_idx = 4'd12;
        #1;
        check128("rd_latency_old_value", rd_key, a1_rk[10]);
        rd(4'd12, 128'h0, "rd_idx12_zero");
        rd(4'd15, 128'h0, "rd_idx15_zero");

        // Restart with keys_valid=1; mid-expansion start with another key is ignored
        start_exp(KEY_A1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        key_in = KEY_ZERO;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check1("ignored_start_busy", busy, 1'b1);
        wait_done(5, n);
        check_done_phase("ignore", n);
        rd(4'd0, KEY_A1, "ignore_slot0");
        rd(4'd1, a1_rk[1], "ignore_slot1");
        rd(4'd10, a1_rk[10], "ignore_slot10");

        // Reset in EXPAND cycle 4 aborts without a done pulse
        start_exp(KEY_ZERO);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_valid", keys_valid, 1'b0);
        check1("abort_done", done, 1'b0);
        check128("abort_rd_key", rd_key, 128'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check1("abort_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        rd(4'd0, 128'h0, "abort_slot0");
        rd(4'd2, 128'h0, "abort_slot2");
        rd(4'd10, 128'h0, "abort_slot10");

        // Start accepted at the first edge after reset release
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        start_exp(KEY_A1);
        wait_done(0, n);
        check_done_phase("recover", n);

        // Back-to-back: start held through the done cycle with the all-zero key
        key_in = KEY_ZERO;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        check1("b2b_busy", busy, 1'b1);
        check1("b2b_valid_drop", keys_valid, 1'b0);
        check1("b2b_done_low", done, 1'b0);
        wait_done(0, n);
        check_done_phase("b2b", n);
        rd(4'd0, KEY_ZERO, "b2b_slot0");
        rd(4'd1, z_rk1, "b2b_slot1");
        rd(4'd2, z_rk2, "b2b_slot2");
        rd(4'd10, z_rk10, "b2b_slot10");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameter REG_RD, default 1: 1 = registered read port (1-cycle latency); 0 = combinational read port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request expansion of key_in; sampled only in IDLE.
REQ-005 key_in  input  128  AES-128 cipher key; w0 = key_in[127:96], w3 = key_in[31:0], byte 0 = key_in[127:120].
REQ-006 busy  output  1  high while in EXPAND.
REQ-007 done  output  1  one-cycle pulse when round key 10 is stored.
REQ-008 keys_valid  output  1  high when all 11 stored round keys belong to the last captured key.
REQ-009 rd_idx  input  4  round-key index, 0..10.
REQ-010 rd_key  output  128  stored round key selected by rd_idx, same word/byte order as key_in.

Function
REQ-011 Storage: 11 x 128-bit slots; slot 0 = cipher key, slot r = round key r, per FIPS-197 AES-128.
REQ-012 FSM states: IDLE and EXPAND only.
REQ-013 IDLE with start=1 at an edge: slot 0 <= key_in, rcon <= 8'h01, round <= 1, keys_valid <= 0, enter EXPAND.
REQ-014 EXPAND, each edge: compute slot[round] from slot[round-1] and rcon, then round <= round+1 and rcon <= xtime(rcon).
REQ-015 Next-key rule: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-016 SubWord is the FIPS-197 S-box on each byte; RotWord is {b1,b2,b3,b0}.
REQ-017 xtime: {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00); required sequence is 01,02,04,08,10,20,40,80,1B,36.
REQ-018 Edge that writes slot 10: return to IDLE, busy <= 0, done <= 1 for exactly one cycle, keys_valid <= 1.
REQ-019 Latency: done is high in the 10th cycle after the edge that samples start; busy is high for exactly 10 cycles.
REQ-020 start while in EXPAND is ignored; key_in is not re-sampled.
REQ-021 start in IDLE with keys_valid=1 restarts the schedule; keys_valid drops on the sampling edge.
REQ-022 Back-to-back: start=1 during the done cycle begins a new expansion at that edge.
REQ-023 REG_RD=1: rd_key <= slot[rd_idx] each edge. REG_RD=0: rd_key = slot[rd_idx] combinationally.
REQ-024 rd_idx 11..15: rd_key = 128'h0.
REQ-025 Reads during EXPAND return current slot contents; consumers gate use on keys_valid.

Reset
REQ-026 rst_n=0 asynchronously forces state IDLE, round=0, rcon=8'h01, busy=0, done=0, keys_valid=0, all slots=0, registered rd_key=0.
REQ-027 Reset asserted mid-EXPAND aborts the expansion; done does not pulse.
REQ-028 After rst_n deassertion, the block accepts start at the first rising edge.

Verification
REQ-029 FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c with start pulse -> done after 10 cycles; slot1=a0fafe1788542cb123a339392a6c7605; slot10=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Rcon trace: during A.1, rcon presented at each of the 10 EXPAND edges = 01,02,04,08,10,20,40,80,1B,36.
REQ-031 start pulsed at EXPAND cycle 5 with a different key_in -> no effect; results identical to REQ-029.
REQ-032 rst_n low at EXPAND cycle 4 -> busy=0, keys_valid=0, all slots 0, no done pulse; a subsequent start completes normally.
REQ-033 Read port: rd_idx=0 after A.1 -> key_in echoed (1-cycle latency when REG_RD=1); rd_idx=12 -> 128'h0.
REQ-034 Back-to-back: start held high through the done cycle with key_in=all-zero key -> second done 10 cycles later; slot10=b4ef5bcb3e92e21123e951cf6f8f188e.
